// File: rtl/network_scheduler.sv
// network_scheduler
//   Top-level sequencer for a dataflow network of NUM_ACTORS trigger
//   controllers. One ap_start/ap_done/ap_ready/ap_idle handshake for the
//   whole network. Each run fires a single-cycle start to every trigger and
//   then waits until all triggers have reported done. While running it
//   derives a debounced network_idle that the triggers use to decide between
//   standing by and relaunching.
//
// Ports
//   ap_clk            clock, rising edge
//   ap_rst_n          asynchronous active-low reset
//   ap_start          network start request (sampled in IDLE only)
//   ap_done/ap_ready  one-cycle pulse when a run completes
//   ap_idle           high while IDLE
//   trigger_start     per-trigger start pulse (all ones for one cycle)
//   trigger_done      per-trigger ap_done pulses
//   trigger_sleeping  per-trigger "waiting on input"
//   fifo_empty_all    every inter-actor FIFO is empty
//   network_idle      debounced quiet indication, fed back to all triggers
//   iterations        completed-run counter (wraps at 2^32)
//   timeout           watchdog flag (only with NETWORK_SCHEDULER_WATCHDOG_EN)
//
// Build option
//   NETWORK_SCHEDULER_WATCHDOG_EN: adds a RUN-state inactivity watchdog of
//   WATCHDOG_CYCLES cycles and the timeout port. Without it RUN waits
//   indefinitely and WATCHDOG_CYCLES only takes part in parameter checking.

module network_scheduler #(
    parameter int NUM_ACTORS      = 4,
    parameter int QUIESCE_CYCLES  = 3,
    parameter int WATCHDOG_CYCLES = 65535
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic [NUM_ACTORS-1:0] trigger_start,
    input  logic [NUM_ACTORS-1:0] trigger_done,
    input  logic [NUM_ACTORS-1:0] trigger_sleeping,
    input  logic                  fifo_empty_all,
    output logic                  network_idle,
    output logic [31:0]           iterations
`ifdef NETWORK_SCHEDULER_WATCHDOG_EN
    ,
    output logic                  timeout
`endif
);

    if (NUM_ACTORS < 1 || QUIESCE_CYCLES < 1 || WATCHDOG_CYCLES < 1) begin : g_param_check
        $error("network_scheduler: NUM_ACTORS, QUIESCE_CYCLES and WATCHDOG_CYCLES must be >= 1");
    end

    localparam int QW = $clog2(QUIESCE_CYCLES + 1);
    localparam logic [QW-1:0] Q_MAX = QW'(QUIESCE_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;

    state_t                  state_reg, state_next;
    logic [NUM_ACTORS-1:0]   done_mask_reg;
    logic [QW-1:0]           quiesce_cnt_reg;
    logic [31:0]             iterations_reg;
    logic [NUM_ACTORS-1:0]   quiet_bits;
    logic                    cond;
    logic                    done_all;
    logic                    wd_expire;

    // A trigger counts as quiet if it is sleeping or has already finished.
    for (genvar gi = 0; gi < NUM_ACTORS; gi++) begin : g_quiet
        assign quiet_bits[gi] = trigger_sleeping[gi] | done_mask_reg[gi];
    end

    assign cond     = fifo_empty_all & (&quiet_bits);
    // Include this cycle's dones so the run ends the cycle after the last one.
    assign done_all = &(done_mask_reg | trigger_done);

`ifdef NETWORK_SCHEDULER_WATCHDOG_EN
    localparam int WW = $clog2(WATCHDOG_CYCLES + 1);

    logic [WW-1:0]         wd_cnt_reg, wd_cnt_next;
    logic [NUM_ACTORS-1:0] sleeping_prev_reg;
    logic                  timeout_reg;
    logic                  activity;

    assign activity    = (|trigger_done) | (trigger_sleeping != sleeping_prev_reg);
    assign wd_cnt_next = activity ? '0 : wd_cnt_reg + WW'(1);
    assign wd_expire   = (state_reg == S_RUN) && (wd_cnt_next == WW'(WATCHDOG_CYCLES));
    assign timeout     = timeout_reg;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wd_cnt_reg        <= '0;
            sleeping_prev_reg <= '0;
            timeout_reg       <= 1'b0;
        end else begin
            sleeping_prev_reg <= trigger_sleeping;
            if (state_reg == S_START) begin
                // Clearing here means RUN is always entered with a fresh count.
                wd_cnt_reg  <= '0;
                timeout_reg <= 1'b0;
            end else if (state_reg == S_RUN) begin
                wd_cnt_reg <= wd_cnt_next;
                if (wd_expire) begin
                    timeout_reg <= 1'b1;
                end
            end
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (ap_start) state_next = S_START;
            S_START: state_next = S_RUN;
            S_RUN:   if (done_all || wd_expire) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic; decoded from the state register so the start pulse is
    // exactly one cycle wide and reset takes effect immediately.
    always_comb begin
        ap_idle       = 1'b0;
        ap_done       = 1'b0;
        ap_ready      = 1'b0;
        trigger_start = '0;
        case (state_reg)
            S_IDLE:  ap_idle = 1'b1;
            S_START: trigger_start = '1;
            S_DONE: begin
                ap_done  = 1'b1;
                ap_ready = 1'b1;
            end
            default: ;
        endcase
    end

    // network_idle drops combinationally the first cycle cond falls.
    assign network_idle = (state_reg == S_RUN) && cond && (quiesce_cnt_reg == Q_MAX);
    assign iterations   = iterations_reg;

    // Datapath: completion mask, quiesce debounce counter, run counter
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            done_mask_reg   <= '0;
            quiesce_cnt_reg <= '0;
            iterations_reg  <= '0;
        end else begin
            case (state_reg)
                S_START: begin
                    // Dones arriving alongside the start pulse still count.
                    done_mask_reg   <= trigger_done;
                    quiesce_cnt_reg <= '0;
                end
                S_RUN: begin
                    done_mask_reg <= done_mask_reg | trigger_done;
                    if (!cond) begin
                        quiesce_cnt_reg <= '0;
                    end else if (quiesce_cnt_reg != Q_MAX) begin
                        quiesce_cnt_reg <= quiesce_cnt_reg + QW'(1);
                    end
                end
                S_DONE: begin
                    iterations_reg  <= iterations_reg + 32'd1;
                    quiesce_cnt_reg <= '0;
                end
                default: quiesce_cnt_reg <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_network_scheduler.sv
// Testbench for network_scheduler (NUM_ACTORS=4, QUIESCE_CYCLES=3,
// WATCHDOG_CYCLES=8). The driver issues one directed vector per clock cycle
// and queues the hand-computed expected outputs for that cycle; a monitor
// on the falling edge pops and compares them, and a second queue holds the
// expected iterations value for every ap_done pulse.

module tb_network_scheduler;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done;
    logic        ap_ready;
    logic        ap_idle;
    logic [3:0]  trigger_start;
    logic [3:0]  trigger_done;
    logic [3:0]  trigger_sleeping;
    logic        fifo_empty_all;
    logic        network_idle;
    logic [31:0] iterations;
`ifdef NETWORK_SCHEDULER_WATCHDOG_EN
    logic        timeout;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        int          k;
        logic        idle;
        logic        done;
        logic [3:0]  tstart;
        logic        nidle;
        logic [31:0] iter;
        logic [1:0]  to;      // 0/1 expected timeout, 2 = not compared
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] done_q[$];
    string       cur_test;

    network_scheduler #(
        .NUM_ACTORS      (4),
        .QUIESCE_CYCLES  (3),
        .WATCHDOG_CYCLES (8)
    ) dut (
        .ap_clk           (ap_clk),
        .ap_rst_n         (ap_rst_n),
        .ap_start         (ap_start),
        .ap_done          (ap_done),
        .ap_ready         (ap_ready),
        .ap_idle          (ap_idle),
        .trigger_start    (trigger_start),
        .trigger_done     (trigger_done),
        .trigger_sleeping (trigger_sleeping),
        .fifo_empty_all   (fifo_empty_all),
        .network_idle     (network_idle),
        .iterations       (iterations)
`ifdef NETWORK_SCHEDULER_WATCHDOG_EN
        ,
        .timeout          (timeout)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s k=%0d: got %0h, expected %0h", name, k, act, req);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    exp_t e;
    always @(negedge ap_clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.name, ".ap_idle"},       e.k, 32'(ap_idle),       32'(e.idle));
            chk({e.name, ".ap_done"},       e.k, 32'(ap_done),       32'(e.done));
            chk({e.name, ".ap_ready"},      e.k, 32'(ap_ready),      32'(e.done));
            chk({e.name, ".trigger_start"}, e.k, 32'(trigger_start), 32'(e.tstart));
            chk({e.name, ".network_idle"},  e.k, 32'(network_idle),  32'(e.nidle));
            chk({e.name, ".iterations"},    e.k, iterations,         e.iter);
`ifdef NETWORK_SCHEDULER_WATCHDOG_EN
            if (e.to != 2'd2) begin
                chk({e.name, ".timeout"}, e.k, 32'(timeout), 32'(e.to[0]));
            end
`endif
        end
        if (ap_done) begin
            if (done_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got ap_done=1 iterations=%0d, expected no pulse", iterations);
            end else begin
                chk("done_event.iterations", -1, iterations, done_q.pop_front());
                $display("done transaction: iterations=%0d ap_ready=%0b", iterations, ap_ready);
            end
        end
    end

    // Drive one cycle of inputs and queue the expected outputs for that cycle.
    task automatic cyc(input int k, input logic st, input logic [3:0] dn, input logic [3:0] slp,
                       input logic fe, input logic rn,
                       input logic e_idle, input logic e_done, input logic [3:0] e_ts,
                       input logic e_ni, input logic [31:0] e_it, input logic [1:0] e_to);
        exp_t x;
        ap_start         = st;
        trigger_done     = dn;
        trigger_sleeping = slp;
        fifo_empty_all   = fe;
        ap_rst_n         = rn;
        x.name   = cur_test;
        x.k      = k;
        x.idle   = e_idle;
        x.done   = e_done;
        x.tstart = e_ts;
        x.nidle  = e_ni;
        x.iter   = e_it;
        x.to     = e_to;
        exp_q.push_back(x);
        if (e_done) done_q.push_back(e_it);
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        logic [3:0] dn;
        ap_rst_n = 1'b0; ap_start = 1'b0; trigger_done = '0;
        trigger_sleeping = '0; fifo_empty_all = 1'b0;
        @(posedge ap_clk);
        #1;

        // Reset values, then 20 IDLE cycles with a quiet network present:
        // network_idle must stay low outside RUN.
        cur_test = "reset";
        for (int k = 0; k < 2; k++)
            cyc(k, 1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 0, 2'd0);
        cur_test = "idle";
        for (int k = 0; k < 20; k++)
            cyc(k, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 0, 2'd0);

        // Basic run: start at k0, dones on bits 0..3 at k5,7,9,11.
        cur_test = "basic_run";
        for (int k = 0; k <= 13; k++) begin
            dn = (k == 5) ? 4'b0001 : (k == 7) ? 4'b0010 : (k == 9) ? 4'b0100 : (k == 11) ? 4'b1000 : 4'b0000;
            cyc(k, k == 0, dn, 4'b0000, 1'b0, 1'b1,
                k == 0 || k == 13, k == 12, (k == 1) ? 4'b1111 : 4'b0000, 1'b0,
                (k >= 13) ? 32'd1 : 32'd0, 2'd0);
        end

        // Quiesce: sleeping/fifo quiet from k10, fifo drops at k15 only.
        cur_test = "quiesce";
        for (int k = 0; k <= 22; k++) begin
            dn = (k == 6) ? 4'b0001 : (k == 14) ? 4'b0010 : (k == 18) ? 4'b0100 : (k == 20) ? 4'b1000 : 4'b0000;
            cyc(k, k == 0, dn, (k >= 10) ? 4'b1111 : 4'b0000, k >= 10 && k != 15, 1'b1,
                k == 0 || k == 22, k == 21, (k == 1) ? 4'b1111 : 4'b0000,
                (k >= 13 && k <= 14) || (k >= 19 && k <= 20),
                (k >= 22) ? 32'd2 : 32'd1, 2'd0);
        end

        // Done in START cycle, rest two cycles later; ap_start held high
        // through DONE relaunches at k6; the second run carries a duplicate
        // done on bit 0 that must not disturb completion.
        cur_test = "start_done_dup";
        for (int k = 0; k <= 14; k++) begin
            case (k)
                1, 4, 8, 9: dn = 4'b0001;
                3:          dn = 4'b1110;
                10:         dn = 4'b0010;
                11:         dn = 4'b0100;
                12:         dn = 4'b1000;
                default:    dn = 4'b0000;
            endcase
            cyc(k, k <= 5, dn, 4'b0000, 1'b0, 1'b1,
                k == 0 || k == 5 || k == 14, k == 4 || k == 13,
                (k == 1 || k == 6) ? 4'b1111 : 4'b0000, 1'b0,
                (k < 5) ? 32'd2 : (k < 14) ? 32'd3 : 32'd4, 2'd0);
        end

        // Reset at k6 of a run with done_mask=0011: abandoned, no ap_done.
        cur_test = "mid_reset";
        for (int k = 0; k <= 10; k++) begin
            dn = (k == 3) ? 4'b0001 : (k == 4) ? 4'b0010 : 4'b0000;
            cyc(k, k == 0, dn, 4'b0000, 1'b0, !(k == 6 || k == 7),
                k == 0 || k >= 6, 1'b0, (k == 1) ? 4'b1111 : 4'b0000, 1'b0,
                (k < 6) ? 32'd4 : 32'd0, 2'd0);
        end

        // Every trigger finishes in the START cycle itself.
        cur_test = "all_done_in_start";
        for (int k = 0; k <= 4; k++)
            cyc(k, k == 0, (k == 1) ? 4'b1111 : 4'b0000, 4'b0000, 1'b0, 1'b1,
                k == 0 || k == 4, k == 3, (k == 1) ? 4'b1111 : 4'b0000, 1'b0,
                (k >= 4) ? 32'd1 : 32'd0, 2'd0);

`ifdef NETWORK_SCHEDULER_WATCHDOG_EN
        // No activity after START: watchdog ends the run 8 cycles into RUN,
        // timeout is sticky until the next START.
        cur_test = "watchdog";
        for (int k = 0; k <= 15; k++)
            cyc(k, k == 0 || k == 11, (k == 12) ? 4'b1111 : 4'b0000, 4'b0000, 1'b0, 1'b1,
                k == 0 || k == 11 || k == 15, k == 10 || k == 14,
                (k == 1 || k == 12) ? 4'b1111 : 4'b0000, 1'b0,
                (k < 11) ? 32'd1 : (k < 15) ? 32'd2 : 32'd3,
                (k == 12) ? 2'd2 : (k == 10 || k == 11) ? 2'd1 : 2'd0);
`endif

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL exp_queue_drain: got %0d pending, expected 0", exp_q.size());
        end
        checks++;
        if (done_q.size() != 0) begin
            errors++;
            $display("FAIL missing_done: got %0d expected pulses not seen, expected 0", done_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
